// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - shared state encodings, defaults and width helper for the Manchester frame controller
package manchester_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_GUARD   = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hD5;

    // Smallest r with 2**r >= value; sizes counters and FIFO pointers.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/manchester_byte_fifo.sv
// rtl/manchester_byte_fifo.sv - first-word-fall-through FIFO of {last, data} words
// Ports: clk/rst (sync active-high), push/push_data write side, pop/pop_data FWFT read side,
//        full/empty status. A push while full succeeds when a pop happens in the same cycle.
module manchester_byte_fifo
    import manchester_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [8:0] push_data,
    input  logic       pop,
    output logic [8:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = clog2(DEPTH);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/manchester_frame_ctrl.sv
// rtl/manchester_frame_ctrl.sv - sync hunt, slip request and frame-to-byte assembly for a Manchester decoder
// Ports: aclk/areset (sync active-high); enable; in_bits/in_num decoded bits (0..2 per cycle, in_bits[1]
//        earlier when two); slip pulse to decoder; m_axis_* byte stream with tlast on the frame's final
//        byte; locked while in payload; frame_err abort pulse; overflow sticky until reset.
module manchester_frame_ctrl
    import manchester_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter int         FRAME_BYTES  = 16,
    parameter int         HUNT_LIMIT   = 64,
    parameter int         SLIP_GUARD   = 4,
    parameter int         IDLE_TIMEOUT = 32,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       enable,
    input  logic [1:0] in_bits,
    input  logic [1:0] in_num,
    output logic       slip,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       locked,
    output logic       frame_err,
    output logic       overflow
);
    localparam int HW = clog2(HUNT_LIMIT + 2);
    localparam int GW = clog2(SLIP_GUARD + 1);
    localparam int IW = clog2(IDLE_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [7:0]    window_q, window_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [HW-1:0] hunt_cnt_q, hunt_cnt_d;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          slip_q, slip_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic [8:0]    push_word;
    logic [8:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          stop;
    logic          take;
    logic          b;

    manchester_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 8'h00 : fifo_rdata[7:0];
    assign m_axis_tlast  = !fifo_empty && fifo_rdata[8];
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign locked        = (state_q == ST_PAYLOAD);
    assign slip          = slip_q;
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;

    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        hunt_cnt_d  = hunt_cnt_q;
        guard_cnt_d = guard_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        overflow_d  = overflow_q;
        slip_d      = 1'b0;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_word   = 9'd0;
        stop        = 1'b0;
        take        = 1'b0;
        b           = 1'b0;

        if (!enable || (in_num == 2'd3 && state_q != ST_GUARD)) begin
            // Disable drops the frame silently; an illegal bit count is reported.
            frame_err_d = enable;
            state_d     = ST_HUNT;
            window_d    = '0;
            hunt_cnt_d  = '0;
        end else if (state_q == ST_GUARD) begin
            if (guard_cnt_q == GW'(SLIP_GUARD - 1)) begin
                state_d     = ST_HUNT;
                hunt_cnt_d  = '0;
                guard_cnt_d = '0;
            end else begin
                guard_cnt_d = guard_cnt_q + GW'(1);
            end
        end else if (state_q == ST_PAYLOAD && in_num == 2'd0) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
            if (idle_cnt_d == IW'(IDLE_TIMEOUT)) begin
                frame_err_d = 1'b1;
                state_d     = ST_HUNT;
            end
        end else begin
            idle_cnt_d = '0;
            // Bits are consumed in arrival order; state_d may change between the two, so the
            // second bit of a pair can land in payload (sync mid-pair) or in the hunt window
            // (frame ended mid-pair).
            for (int i = 0; i < 2; i++) begin
                take = (i == 0) ? (in_num != 2'd0) : (in_num == 2'd2);
                b    = (i == 0 && in_num == 2'd2) ? in_bits[1] : in_bits[0];
                if (take && !stop) begin
                    if (state_d == ST_HUNT) begin
                        window_d = {window_d[6:0], b};
                        if (window_d == SYNC_WORD) begin
                            state_d    = ST_PAYLOAD;
                            window_d   = '0;
                            hunt_cnt_d = '0;
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                        end
                    end else begin
                        shift_d = {shift_d[6:0], b};
                        if (bit_cnt_d == 3'd7) begin
                            bit_cnt_d = '0;
                            if (fifo_full && !pop) begin
                                overflow_d  = 1'b1;
                                frame_err_d = 1'b1;
                                state_d     = ST_HUNT;
                                stop        = 1'b1;
                            end else begin
                                push      = 1'b1;
                                push_word = {byte_cnt_d == 8'(FRAME_BYTES - 1), shift_d};
                                if (push_word[8]) begin
                                    state_d    = ST_HUNT;
                                    hunt_cnt_d = '0;
                                end else begin
                                    byte_cnt_d = byte_cnt_d + 8'd1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_d + 3'd1;
                        end
                    end
                end
            end
            if (state_q == ST_HUNT && state_d == ST_HUNT) begin
                hunt_cnt_d = hunt_cnt_q + HW'(in_num);
                if (hunt_cnt_d >= HW'(HUNT_LIMIT)) begin
                    slip_d      = 1'b1;
                    window_d    = '0;
                    hunt_cnt_d  = '0;
                    guard_cnt_d = '0;
                    state_d     = ST_GUARD;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_HUNT;
            window_q    <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            hunt_cnt_q  <= '0;
            guard_cnt_q <= '0;
            idle_cnt_q  <= '0;
            slip_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            hunt_cnt_q  <= hunt_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            slip_q      <= slip_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_manchester_frame_ctrl.sv
// tb/tb_manchester_frame_ctrl.sv - directed self-checking bench for manchester_frame_ctrl
module tb_manchester_frame_ctrl;

    logic       aclk = 1'b0;
    logic       areset;
    logic       enable;
    logic [1:0] in_bits;
    logic [1:0] in_num;
    logic       slip;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       locked;
    logic       frame_err;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    logic [8:0] rx_q [$];

    manchester_frame_ctrl dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .in_bits       (in_bits),
        .in_num        (in_num),
        .slip          (slip),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .locked        (locked),
        .frame_err     (frame_err),
        .overflow      (overflow)
    );

    always #5 aclk = ~aclk;

    // Handshakes complete on the next rising edge; inputs are stable at the falling edge.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) rx_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    task automatic cyc(input logic [1:0] num, input logic [1:0] bits);
        in_num  = num;
        in_bits = bits;
        @(posedge aclk);
        #1;
        in_num  = 2'd0;
        in_bits = 2'd0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) cyc(2'd1, {1'b0, v[i]});
    endtask

    task automatic do_reset();
        areset = 1'b1;
        cyc(2'd0, 2'd0);
        areset = 1'b0;
        rx_q.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        cyc(2'd0, 2'd0);
        cyc(2'd0, 2'd0);
        checks++;
        if ({slip, m_axis_tvalid, m_axis_tlast, locked, frame_err, overflow} !== 6'b0)
            begin errors++; $display("FAIL reset_flags got=%b exp=000000", {slip, m_axis_tvalid, m_axis_tlast, locked, frame_err, overflow}); end
        checks++;
        if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h exp=00", m_axis_tdata); end
        areset = 1'b0;
        rx_q.delete();
    endtask

    task automatic test_serial_frame();
        logic [7:0] sw;
        sw = 8'hD5;
        for (int i = 7; i >= 0; i--) begin
            cyc(2'd1, {1'b0, sw[i]});
            if (i == 1) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL t1_lock_early got=%b exp=0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL t1_lock got=%b exp=1", locked); end
        send_byte(8'h00);
        checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== 9'h100) begin errors++; $display("FAIL t1_latency got=%h exp=100", {m_axis_tvalid, m_axis_tdata}); end
        for (int k = 1; k < 16; k++) send_byte(8'(k));
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL t1_unlock got=%b exp=0", locked); end
        repeat (3) cyc(2'd0, 2'd0);
        checks++;
        if (rx_q.size() != 16) begin errors++; $display("FAIL t1_count got=%0d exp=16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {(i == 15), 8'(i)}) begin errors++; $display("FAIL t1_beat%0d got=%h exp=%h", i, rx_q[i], {(i == 15), 8'(i)}); end
        end
    endtask

    task automatic test_dual_bit_frame();
        logic bq [$];
        logic [7:0] v;
        int idx;
        int pair;
        do_reset();
        bq.push_back(1'b0);
        v = 8'hD5;
        for (int i = 7; i >= 0; i--) bq.push_back(v[i]);
        for (int k = 0; k < 16; k++) begin
            v = 8'(k);
            for (int i = 7; i >= 0; i--) bq.push_back(v[i]);
        end
        idx = 0;
        pair = 0;
        while (idx + 1 < bq.size()) begin
            cyc(2'd2, {bq[idx], bq[idx + 1]});
            idx += 2;
            pair++;
            if (pair == 4) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL t2_lock_early got=%b exp=0", locked); end
            end
            if (pair == 5) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL t2_lock_midpair got=%b exp=1", locked); end
            end
        end
        if (idx < bq.size()) cyc(2'd1, {1'b0, bq[idx]});
        repeat (3) cyc(2'd0, 2'd0);
        checks++;
        if (rx_q.size() != 16) begin errors++; $display("FAIL t2_count got=%0d exp=16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {(i == 15), 8'(i)}) begin errors++; $display("FAIL t2_beat%0d got=%h exp=%h", i, rx_q[i], {(i == 15), 8'(i)}); end
        end
    endtask

    task automatic test_slip();
        logic [7:0] sw;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            cyc(2'd1, {1'b0, ~i[0]});
            if (i == 62) begin
                checks++;
                if (slip !== 1'b0) begin errors++; $display("FAIL t3_slip_early got=%b exp=0", slip); end
            end
        end
        checks++;
        if ({slip, locked} !== 2'b10) begin errors++; $display("FAIL t3_slip got=%b exp=10", {slip, locked}); end
        for (int g = 0; g < 4; g++) begin
            cyc(2'd1, 2'b01);
            if (g == 0) begin
                checks++;
                if (slip !== 1'b0) begin errors++; $display("FAIL t3_slip_pulse got=%b exp=0", slip); end
            end
        end
        sw = 8'hD5;
        for (int i = 7; i >= 0; i--) begin
            cyc(2'd1, {1'b0, sw[i]});
            if (i == 1) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL t3_relock_early got=%b exp=0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL t3_relock got=%b exp=1", locked); end
    endtask

    task automatic test_idle_timeout();
        logic [7:0] exp4 [3];
        exp4 = '{8'hA1, 8'hB2, 8'hC3};
        do_reset();
        send_byte(8'hD5);
        for (int k = 0; k < 3; k++) send_byte(exp4[k]);
        repeat (31) cyc(2'd0, 2'd0);
        checks++;
        if ({locked, frame_err} !== 2'b10) begin errors++; $display("FAIL t4_before_timeout got=%b exp=10", {locked, frame_err}); end
        cyc(2'd0, 2'd0);
        checks++;
        if ({locked, frame_err} !== 2'b01) begin errors++; $display("FAIL t4_timeout got=%b exp=01", {locked, frame_err}); end
        cyc(2'd0, 2'd0);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL t4_err_pulse got=%b exp=0", frame_err); end
        checks++;
        if (rx_q.size() != 3) begin errors++; $display("FAIL t4_count got=%0d exp=3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {1'b0, exp4[i]}) begin errors++; $display("FAIL t4_beat%0d got=%h exp=%h", i, rx_q[i], {1'b0, exp4[i]}); end
        end
    endtask

    task automatic test_abort_inputs();
        do_reset();
        send_byte(8'hD5);
        send_byte(8'h5A);
        cyc(2'd3, 2'b11);
        checks++;
        if ({locked, frame_err} !== 2'b01) begin errors++; $display("FAIL t_num3 got=%b exp=01", {locked, frame_err}); end
        send_byte(8'hD5);
        cyc(2'd1, 2'b01);
        enable = 1'b0;
        cyc(2'd1, 2'b01);
        enable = 1'b1;
        checks++;
        if ({locked, frame_err} !== 2'b00) begin errors++; $display("FAIL t_disable got=%b exp=00", {locked, frame_err}); end
        cyc(2'd0, 2'd0);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 9'h05A) begin errors++; $display("FAIL t_abort_out got=%0d bytes exp=1 byte 05a", rx_q.size()); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] v;
        do_reset();
        m_axis_tready = 1'b0;
        send_byte(8'hD5);
        for (int k = 0; k < 4; k++) send_byte(8'(k));
        v = 8'h04;
        for (int i = 7; i >= 1; i--) cyc(2'd1, {1'b0, v[i]});
        m_axis_tready = 1'b1;
        cyc(2'd1, {1'b0, v[0]});
        checks++;
        if ({overflow, frame_err, locked} !== 3'b001) begin errors++; $display("FAIL t_pushpop_flags got=%b exp=001", {overflow, frame_err, locked}); end
        repeat (6) cyc(2'd0, 2'd0);
        checks++;
        if (rx_q.size() != 5) begin errors++; $display("FAIL t_pushpop_count got=%0d exp=5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {1'b0, 8'(i)}) begin errors++; $display("FAIL t_pushpop_beat%0d got=%h exp=%h", i, rx_q[i], {1'b0, 8'(i)}); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        m_axis_tready = 1'b0;
        send_byte(8'hD5);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'(k));
            checks++;
            if ({m_axis_tvalid, m_axis_tdata} !== 9'h100) begin errors++; $display("FAIL t5_stall%0d got=%h exp=100", k, {m_axis_tvalid, m_axis_tdata}); end
        end
        send_byte(8'h04);
        checks++;
        if ({overflow, frame_err, locked} !== 3'b110) begin errors++; $display("FAIL t5_overflow got=%b exp=110", {overflow, frame_err, locked}); end
        m_axis_tready = 1'b1;
        repeat (6) cyc(2'd0, 2'd0);
        checks++;
        if ({overflow, frame_err, m_axis_tvalid} !== 3'b100) begin errors++; $display("FAIL t5_after got=%b exp=100", {overflow, frame_err, m_axis_tvalid}); end
        checks++;
        if (rx_q.size() != 4) begin errors++; $display("FAIL t5_count got=%0d exp=4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {1'b0, 8'(i)}) begin errors++; $display("FAIL t5_beat%0d got=%h exp=%h", i, rx_q[i], {1'b0, 8'(i)}); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        m_axis_tready = 1'b0;
        rx_q.delete();
        send_byte(8'hD5);
        for (int k = 0; k < 4; k++) send_byte(8'(k));
        v = 8'h04;
        for (int i = 7; i >= 4; i--) cyc(2'd1, {1'b0, v[i]});
        do_reset();
        checks++;
        if ({slip, m_axis_tvalid, m_axis_tlast, locked, frame_err, overflow, m_axis_tdata} !== 14'b0)
            begin errors++; $display("FAIL t6_reset got=%b exp=0", {slip, m_axis_tvalid, m_axis_tlast, locked, frame_err, overflow, m_axis_tdata}); end
        m_axis_tready = 1'b1;
        send_byte(8'hD5);
        for (int k = 0; k < 16; k++) send_byte(8'h30 + 8'(k));
        repeat (3) cyc(2'd0, 2'd0);
        checks++;
        if (rx_q.size() != 16) begin errors++; $display("FAIL t6_count got=%0d exp=16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {(i == 15), 8'h30 + 8'(i)}) begin errors++; $display("FAIL t6_beat%0d got=%h exp=%h", i, rx_q[i], {(i == 15), 8'h30 + 8'(i)}); end
        end
    endtask

    initial begin
        areset        = 1'b1;
        enable        = 1'b1;
        in_bits       = 2'd0;
        in_num        = 2'd0;
        m_axis_tready = 1'b1;
        test_reset();
        test_serial_frame();
        test_dual_bit_frame();
        test_slip();
        test_idle_timeout();
        test_abort_inputs();
        test_full_push_pop();
        test_overflow();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
